decode_unit: RTL and testbench

DECODE_UNIT -- requirements
Module: decode_unit

---
 rtl/decode_unit.sv | 143 ++++++++++++++
 tb/tb_decode_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_unit.sv
// ID stage: register file with EX/MEM and MEM/WB bypass, load-use stall, early branch resolve, ID/EX register.
// Latency: one cycle from IF/ID into ID/EX. Backpressure: ID/EX holds while out_valid & !out_ready, and in_ready drops.
module decode_unit #(
    parameter int          XLEN   = 32,
    parameter int          NREG   = 32,
    parameter logic [5:0]  BEQ_OP = 6'h04,
    parameter logic [5:0]  BNE_OP = 6'h05,
    parameter logic [5:0]  LW_OP  = 6'h23,
    parameter logic [5:0]  SW_OP  = 6'h2B,
    localparam int         RW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            in_ready,
    input  logic            flush,
    input  logic            exm_we,
    input  logic [RW-1:0]   exm_rd,
    input  logic [XLEN-1:0] exm_value,
    input  logic            wb_we,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_value,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [31:0]     out_ir,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [XLEN-1:0] out_pc,
    output logic            load_stall,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target
);

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];

    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_ir_q, out_ir_d;
    logic [XLEN-1:0] out_a_q, out_a_d;
    logic [XLEN-1:0] out_b_q, out_b_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;

    logic [5:0]      op;
    logic [RW-1:0]   rs_idx, rt_idx, lw_rt;
    logic            uses_rt;
    logic [XLEN-1:0] op_a, op_b;
    logic [XLEN-1:0] br_off;
    logic            advance;

    assign op     = in_ir[31:26];
    assign rs_idx = in_ir[21 +: RW];
    assign rt_idx = in_ir[16 +: RW];
    assign lw_rt  = out_ir_q[16 +: RW];

    always_comb begin
        rf_d = rf_q;
        if (wb_we && wb_rd != '0) begin
            rf_d[wb_rd] = wb_value;
        end
    end

    // Younger producer (EX/MEM) wins over MEM/WB; r0 is hard zero.
    always_comb begin
        op_a = rf_q[rs_idx];
        if (rs_idx == '0)                       op_a = '0;
        else if (exm_we && exm_rd == rs_idx)    op_a = exm_value;
        else if (wb_we && wb_rd == rs_idx)      op_a = wb_value;

        op_b = rf_q[rt_idx];
        if (rt_idx == '0)                       op_b = '0;
        else if (exm_we && exm_rd == rt_idx)    op_b = exm_value;
        else if (wb_we && wb_rd == rt_idx)      op_b = wb_value;
    end

    always_comb begin
        uses_rt    = (op == 6'h00) || (op == BEQ_OP) || (op == BNE_OP) || (op == SW_OP);
        load_stall = in_valid && out_valid_q && (out_ir_q[31:26] == LW_OP) && (lw_rt != '0) &&
                     ((lw_rt == rs_idx) || (uses_rt && lw_rt == rt_idx));
        advance    = !out_valid_q || out_ready;
        in_ready   = advance && !load_stall;
    end

    always_comb begin
        br_off        = {{(XLEN-16){in_ir[15]}}, in_ir[15:0]} << 2;
        branch_target = in_pc + XLEN'(4) + br_off;
        branch_taken  = rst_n && in_valid && in_ready && !flush &&
                        (((op == BEQ_OP) && (op_a == op_b)) || ((op == BNE_OP) && (op_a != op_b)));
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_ir_d    = out_ir_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_pc_d    = out_pc_q;
        if (advance) begin
            out_pc_d = in_pc;
            if (flush || load_stall || !in_valid) begin
                out_valid_d = 1'b0;
                out_ir_d    = 32'h0;
                out_a_d     = '0;
                out_b_d     = '0;
            end else begin
                out_valid_d = 1'b1;
                out_ir_d    = in_ir;
                out_a_d     = op_a;
                out_b_d     = op_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_ir_q    <= 32'h0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_pc_q    <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
            rf_q[0]     <= '0;
            out_valid_q <= out_valid_d;
            out_ir_q    <= out_ir_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ir    = out_ir_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_decode_unit.sv
// Randomized scoreboard bench for decode_unit: driver predicts ID/EX contents, a monitor pops on each handshake.
module tb_decode_unit;
    localparam logic [5:0] BEQ = 6'h04, BNE = 6'h05, LW = 6'h23, SW = 6'h2B;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, exm_we, wb_we, out_ready;
    logic [31:0] in_ir, in_pc, exm_value, wb_value;
    logic [4:0]  exm_rd, wb_rd;
    logic        in_ready, out_valid, load_stall, branch_taken;
    logic [31:0] out_ir, out_a, out_b, out_pc, branch_target;

    decode_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ir(in_ir), .in_pc(in_pc),
        .in_ready(in_ready), .flush(flush), .exm_we(exm_we), .exm_rd(exm_rd),
        .exm_value(exm_value), .wb_we(wb_we), .wb_rd(wb_rd), .wb_value(wb_value),
        .out_ready(out_ready), .out_valid(out_valid), .out_ir(out_ir), .out_a(out_a),
        .out_b(out_b), .out_pc(out_pc), .load_stall(load_stall),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mreg [32];
    logic        mov;
    logic [31:0] mir;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
        if (exm_we && exm_rd == idx) return exm_value;
        if (wb_we && wb_rd == idx) return wb_value;
        return mreg[idx];
    endfunction

    function automatic logic [31:0] r_type(input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h0, 6'h20};
    endfunction

    function automatic logic [31:0] rnd_ir();
        logic [5:0] op;
        case ($urandom_range(0, 5))
            0: op = 6'h00;
            1: op = BEQ;
            2: op = BNE;
            3: op = LW;
            4: op = SW;
            default: op = 6'($urandom_range(0, 63));
        endcase
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
    endfunction

    // Called just after a rising edge with inputs already driven.
    task automatic eval();
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic        uses_rt, stall_e, rdy_e, bt_e;
        logic [31:0] a_e, b_e, tgt_e;
        #1;
        op      = in_ir[31:26];
        rs      = in_ir[25:21];
        rt      = in_ir[20:16];
        a_e     = fwd(rs);
        b_e     = fwd(rt);
        uses_rt = (op == 6'h00) || (op == BEQ) || (op == BNE) || (op == SW);
        stall_e = in_valid && mov && mir[31:26] == LW && mir[20:16] != 0 &&
                  (mir[20:16] == rs || (uses_rt && mir[20:16] == rt));
        rdy_e   = (!mov || out_ready) && !stall_e;
        bt_e    = in_valid && rdy_e && !flush && ((op == BEQ && a_e == b_e) || (op == BNE && a_e != b_e));
        tgt_e   = in_pc + 32'd4 + 32'($signed(in_ir[15:0])) * 4;
        chk("load_stall", 32'(load_stall), 32'(stall_e));
        chk("in_ready", 32'(in_ready), 32'(rdy_e));
        chk("branch_taken", 32'(branch_taken), 32'(bt_e));
        if (bt_e) chk("branch_target", branch_target, tgt_e);
        if (!mov || out_ready) begin
            if (flush || stall_e || !in_valid) begin
                mov = 1'b0;
                mir = 32'h0;
            end else begin
                mov = 1'b1;
                mir = in_ir;
                q.push_back('{ir: in_ir, a: a_e, b: b_e, pc: in_pc});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (wb_we && wb_rd != 0) mreg[wb_rd] = wb_value;
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        mov = 1'b0;
        mir = 32'h0;
        q.delete();
    endtask

    task automatic idle_inputs();
        in_valid = 0; flush = 0; exm_we = 0; wb_we = 0;
        exm_rd = 0; wb_rd = 0; exm_value = 0; wb_value = 0;
        in_ir = 0; in_pc = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_out_ir"}, out_ir, 32'h0);
        chk({tag, "_out_a"}, out_a, 32'h0);
        chk({tag, "_out_b"}, out_b, 32'h0);
        chk({tag, "_out_pc"}, out_pc, 32'h0);
        chk({tag, "_load_stall"}, 32'(load_stall), 32'h0);
        chk({tag, "_branch_taken"}, 32'(branch_taken), 32'h0);
    endtask

    // Monitor: sample away from the active edge; pop on each ID/EX handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: out_ir %h with empty scoreboard", out_ir);
                    end else begin
                        e = q.pop_front();
                        chk("sb_ir", out_ir, e.ir);
                        chk("sb_a", out_a, e.a);
                        chk("sb_b", out_b, e.b);
                        chk("sb_pc", out_pc, e.pc);
                    end
                end
                if (!out_valid) chk("bubble_ir", out_ir, 32'h0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        out_ready = 1;
        idle_inputs();
        model_reset();
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // MEM/WB write, then read it back through the register file.
        wb_we = 1; wb_rd = 5; wb_value = 32'h1234;
        eval(); tick();
        wb_we = 0; in_valid = 1; in_ir = r_type(1, 5, 0); in_pc = 32'h40;
        eval(); tick();
        chk("rf_read_a", out_a, 32'h1234);
        chk("rf_read_b", out_b, 32'h0);

        // EX/MEM beats MEM/WB for the same register.
        exm_we = 1; exm_rd = 3; exm_value = 32'hAA;
        wb_we = 1; wb_rd = 3; wb_value = 32'hBB;
        in_ir = r_type(1, 3, 0); in_pc = 32'h44;
        eval(); tick();
        chk("fwd_priority", out_a, 32'hAA);
        exm_we = 0; wb_we = 0;

        // Load-use: lw r2 followed by add r4,r2,r6.
        in_ir = {LW, 5'd0, 5'd2, 16'h0}; in_pc = 32'h48;
        eval(); tick();
        in_ir = r_type(4, 2, 6); in_pc = 32'h4C;
        eval();
        chk("lu_stall", 32'(load_stall), 32'h1);
        chk("lu_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("lu_bubble_valid", 32'(out_valid), 32'h0);
        chk("lu_bubble_ir", out_ir, 32'h0);
        eval(); tick();
        chk("lu_issue_valid", 32'(out_valid), 32'h1);
        chk("lu_issue_ir", out_ir, r_type(4, 2, 6));

        // Branches resolved in decode.
        in_ir = {BEQ, 5'd1, 5'd1, 16'hFFFF}; in_pc = 32'h100;
        eval();
        chk("beq_taken", 32'(branch_taken), 32'h1);
        chk("beq_target", branch_target, 32'h100);
        tick();
        in_ir = {BNE, 5'd1, 5'd1, 16'h0008}; in_pc = 32'h104;
        eval();
        chk("bne_not_taken", 32'(branch_taken), 32'h0);
        tick();

        // Backpressure: ID/EX holds, then flush on release.
        in_ir = r_type(7, 1, 2); in_pc = 32'h108;
        eval(); tick();
        out_ready = 0; in_ir = r_type(8, 1, 1); in_pc = 32'h10C;
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("hold_in_ready", 32'(in_ready), 32'h0);
            tick();
            chk("hold_valid", 32'(out_valid), 32'h1);
            chk("hold_ir", out_ir, r_type(7, 1, 2));
            chk("hold_pc", out_pc, 32'h108);
        end
        out_ready = 1; flush = 1;
        eval(); tick();
        chk("flush_valid", 32'(out_valid), 32'h0);
        flush = 0;

        // Randomized traffic, with one asynchronous mid-cycle reset.
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                in_valid = 1; in_ir = r_type(9, 1, 2); out_ready = 1;
                #2;
                rst_n = 0;
                idle_inputs();
                #1;
                chk_reset_outputs("async_reset");
                model_reset();
                @(posedge clk);
                #3;
                rst_n = 1;
                @(posedge clk);
                #1;
            end
            in_valid  = ($urandom_range(0, 9) < 8);
            in_ir     = rnd_ir();
            in_pc     = {$urandom} & 32'hFFFF_FFFC;
            flush     = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            exm_we    = $urandom_range(0, 1);
            exm_rd    = 5'($urandom_range(0, 7));
            exm_value = $urandom;
            wb_we     = $urandom_range(0, 1);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_value  = $urandom;
            eval(); tick();
        end

        idle_inputs();
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            eval(); tick();
        end
        chk("scoreboard_drained", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
